// File: rtl/sal_ref_ctrl_pkg.sv
// Shared types and default widths for the SAL refresh controller.
package sal_ref_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ISSUE,
    RFC
  } ref_state_t;

  localparam int DEF_TREFI_W  = 16;
  localparam int DEF_TRFC_W   = 10;
  localparam int DEF_MAX_PEND = 8;

endpackage

// File: rtl/sal_ref_ctrl_timer.sv
// tREFI interval down-counter: one-cycle tick every t_refi cycles while enabled.
module sal_ref_ctrl_timer #(
  parameter int TREFI_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [TREFI_W-1:0] t_refi,
  output logic               tick
);

  logic [TREFI_W-1:0] cnt;
  logic               run;

  assign run  = en && (t_refi != '0);
  assign tick = run && (cnt == TREFI_W'(1));

  // Reload while stopped or at the end of an interval, so a new period applies at the next reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || (cnt <= TREFI_W'(1))) begin
      cnt <= t_refi;
    end else begin
      cnt <= cnt - TREFI_W'(1);
    end
  end

endmodule

// File: rtl/sal_ref_ctrl.sv
// Refresh controller: tracks postponed refreshes and runs the REQ/ISSUE/RFC handshake with the banks.
module sal_ref_ctrl
  import sal_ref_ctrl_pkg::*;
#(
  parameter int BK_CNT     = 8,
  parameter int TREFI_W    = DEF_TREFI_W,
  parameter int TRFC_W     = DEF_TRFC_W,
  parameter int MAX_PEND   = DEF_MAX_PEND,
  parameter int URGENT_THR = 6,
  localparam int PEND_W    = $clog2(MAX_PEND + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ref_en_i,
  input  logic [TREFI_W-1:0] t_refi_i,
  input  logic [TRFC_W-1:0]  t_rfc_i,
  input  logic [BK_CNT-1:0]  bk_idle_i,
  input  logic [BK_CNT-1:0]  ref_gnt_i,
  output logic [BK_CNT-1:0]  ref_req_o,
  output logic               ref_cmd_valid_o,
  input  logic               ref_cmd_ready_i,
  output logic               ref_urgent_o,
  output logic [PEND_W-1:0]  ref_pend_o,
  output logic               ref_ovf_o
);

  ref_state_t        state, state_nxt;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic              ovf, ovf_nxt;
  logic              urgent;
  logic              gnt_q;
  logic [TRFC_W-1:0] rfc_cnt;
  logic              tick;
  logic              hs;

  sal_ref_ctrl_timer #(
    .TREFI_W(TREFI_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ref_en_i),
    .t_refi (t_refi_i),
    .tick   (tick)
  );

  assign hs              = (state == ISSUE) && ref_cmd_ready_i;
  assign ref_req_o       = {BK_CNT{state != IDLE}};
  assign ref_cmd_valid_o = (state == ISSUE);
  assign ref_pend_o      = pend;
  assign ref_urgent_o    = urgent;
  assign ref_ovf_o       = ovf;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ref_en_i && (pend != '0) &&
                   ((pend >= PEND_W'(URGENT_THR)) || (&bk_idle_i))) state_nxt = REQ;
      REQ:     if (gnt_q) state_nxt = ISSUE;
      ISSUE:   if (ref_cmd_ready_i) state_nxt = RFC;
      RFC:     if (rfc_cnt <= TRFC_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A tick and a handshake in the same cycle cancel; a tick at the limit only flags overflow
  always_comb begin
    pend_nxt = pend;
    ovf_nxt  = ovf;
    if (tick && !hs) begin
      if (pend == PEND_W'(MAX_PEND)) ovf_nxt = 1'b1;
      else                           pend_nxt = pend + PEND_W'(1);
    end else if (hs && !tick && (pend != '0)) begin
      pend_nxt = pend - PEND_W'(1);
    end
  end

  // Grants are only captured while requesting, so every sequence needs a fresh grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= '0;
      ovf     <= 1'b0;
      urgent  <= 1'b0;
      gnt_q   <= 1'b0;
      rfc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      ovf    <= ovf_nxt;
      urgent <= (pend_nxt >= PEND_W'(URGENT_THR));
      gnt_q  <= (state == REQ) && (&ref_gnt_i);
      if (hs) begin
        rfc_cnt <= (t_rfc_i == '0) ? TRFC_W'(1) : t_rfc_i;
      end else if ((state == RFC) && (rfc_cnt != '0)) begin
        rfc_cnt <= rfc_cnt - TRFC_W'(1);
      end
    end
  end

endmodule
